// File: rtl/fixed_point_pkg.sv
// Shared fixed-point definitions for the sensor-fusion datapath.
// Used by vec_sum_squares, fastInvSqrt and the vector normaliser.
package fixed_point_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_INT_WIDTH   = 12;
  localparam int DEF_FRACT_WIDTH = 4;

  // Total element width in bits.
  function automatic int elem_width(input int int_w, input int fract_w);
    return int_w + fract_w;
  endfunction

  // Two guard bits above the 2W-bit product, so up to four squares cannot overflow.
  function automatic int acc_width(input int w);
    return 2 * w + 2;
  endfunction

  // Largest positive value of a signed w-bit element.
  function automatic longint sat_limit(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

endpackage

// File: rtl/vec_sum_squares.sv
// Sequential sum of squares of a 3- or 4-element signed fixed-point vector.
// One shared multiplier; result truncated back to the input Q format and saturated.
module vec_sum_squares
  import fixed_point_pkg::*;
#(
  parameter int INT_WIDTH   = DEF_INT_WIDTH,
  parameter int FRACT_WIDTH = DEF_FRACT_WIDTH,
  parameter int N_ELEM      = 3
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [N_ELEM*(INT_WIDTH+FRACT_WIDTH)-1:0]  data_in,
  input  logic                                       valid_in,
  output logic                                       ready_in,
  output logic [INT_WIDTH+FRACT_WIDTH-1:0]           data_out,
  output logic                                       valid_out,
  input  logic                                       ready_out,
  output logic                                       zero_out,
  output logic                                       sat_out
);

  localparam int W     = elem_width(INT_WIDTH, FRACT_WIDTH);
  localparam int ACC_W = acc_width(W);
  localparam int IDX_W = 2;

  localparam logic [ACC_W-1:0] SAT_ACC = ACC_W'(sat_limit(W));
  localparam logic [W-1:0]     SAT_OUT = W'(sat_limit(W));
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  logic signed [W-1:0] w_elem_in [N_ELEM];

  genvar gi;
  generate
    for (gi = 0; gi < N_ELEM; gi++) begin : g_unpack
      assign w_elem_in[gi] = data_in[gi*W +: W];
    end
  endgenerate

  state_t              r_state;
  logic signed [W-1:0] r_elem [N_ELEM];
  logic [IDX_W-1:0]    r_idx;
  logic [ACC_W-1:0]    r_acc;
  logic [W-1:0]        r_data_out;
  logic                r_ready_in;
  logic                r_valid_out;
  logic                r_zero;
  logic                r_sat;

  logic signed [W-1:0]   w_cur;
  logic signed [2*W-1:0] w_prod;
  logic [ACC_W-1:0]      w_sum;
  logic [ACC_W-1:0]      w_result;
  logic                  w_last;
  logic                  w_sat;

  // Full 2W-bit signed product: (-2^(W-1))^2 = 2^(2W-2) still fits as a positive value.
  assign w_cur    = r_elem[r_idx];
  assign w_prod   = w_cur * w_cur;
  assign w_sum    = r_acc + {2'b00, w_prod};
  assign w_result = w_sum >> FRACT_WIDTH;
  assign w_last   = (r_idx == LAST_IDX);
  assign w_sat    = (w_result > SAT_ACC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_acc       <= '0;
      r_data_out  <= '0;
      r_ready_in  <= 1'b1;
      r_valid_out <= 1'b0;
      r_zero      <= 1'b0;
      r_sat       <= 1'b0;
      for (int i = 0; i < N_ELEM; i++) begin
        r_elem[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_in && r_ready_in) begin
            for (int i = 0; i < N_ELEM; i++) begin
              r_elem[i] <= w_elem_in[i];
            end
            r_acc      <= '0;
            r_idx      <= '0;
            r_ready_in <= 1'b0;
            r_state    <= MAC;
          end
        end
        MAC: begin
          r_acc <= w_sum;
          r_idx <= r_idx + 1'b1;
          if (w_last) begin
            r_data_out  <= w_sat ? SAT_OUT : w_result[W-1:0];
            r_sat       <= w_sat;
            r_zero      <= (w_result == '0);
            r_valid_out <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          // Outputs hold until downstream takes them; no accept in this cycle.
          if (ready_out) begin
            r_valid_out <= 1'b0;
            r_ready_in  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_ready_in  <= 1'b1;
          r_valid_out <= 1'b0;
        end
      endcase
    end
  end

  assign ready_in  = r_ready_in;
  assign valid_out = r_valid_out;
  assign data_out  = r_data_out;
  assign zero_out  = r_zero;
  assign sat_out   = r_sat;

endmodule

// File: tb/tb_vec_sum_squares.sv
// Directed bench for vec_sum_squares: 3-element and 4-element instances.
// Expected results are hand-computed from the Q12.4 arithmetic.
module tb_vec_sum_squares;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic [47:0] data_in3 = '0;
  logic        valid_in3 = 1'b0;
  logic        ready_in3;
  logic [15:0] data_out3;
  logic        valid_out3;
  logic        ready_out3 = 1'b0;
  logic        zero_out3;
  logic        sat_out3;

  logic [63:0] data_in4 = '0;
  logic        valid_in4 = 1'b0;
  logic        ready_in4;
  logic [15:0] data_out4;
  logic        valid_out4;
  logic        ready_out4 = 1'b0;
  logic        zero_out4;
  logic        sat_out4;

  int passes = 0;
  int fails  = 0;
  int checks = 0;

  logic        sel4 = 1'b0;
  logic        m_ready_in, m_valid_out, m_zero, m_sat;
  logic [15:0] m_data;

  always #5 clk = ~clk;

  vec_sum_squares #(.INT_WIDTH(12), .FRACT_WIDTH(4), .N_ELEM(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in3), .valid_in(valid_in3),
    .ready_in(ready_in3), .data_out(data_out3), .valid_out(valid_out3),
    .ready_out(ready_out3), .zero_out(zero_out3), .sat_out(sat_out3)
  );

  vec_sum_squares #(.INT_WIDTH(12), .FRACT_WIDTH(4), .N_ELEM(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in4), .valid_in(valid_in4),
    .ready_in(ready_in4), .data_out(data_out4), .valid_out(valid_out4),
    .ready_out(ready_out4), .zero_out(zero_out4), .sat_out(sat_out4)
  );

  always_comb begin
    m_ready_in  = sel4 ? ready_in4  : ready_in3;
    m_valid_out = sel4 ? valid_out4 : valid_out3;
    m_data      = sel4 ? data_out4  : data_out3;
    m_zero      = sel4 ? zero_out4  : zero_out3;
    m_sat       = sel4 ? sat_out4   : sat_out3;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Send one vector, measure latency, check result, stall, then hand off.
  task automatic run_vec(input string name, input logic [63:0] vec, input logic [15:0] exp_d,
                         input logic exp_z, input logic exp_s, input int stall);
    int          cyc;
    int          n_exp;
    n_exp = sel4 ? 4 : 3;
    chk({name, "_ready_in_idle"}, 32'(m_ready_in), 32'd1);
    if (sel4) begin data_in4 = vec; valid_in4 = 1'b1; end
    else begin data_in3 = vec[47:0]; valid_in3 = 1'b1; end
    @(posedge clk); #1;
    chk({name, "_ready_in_busy"}, 32'(m_ready_in), 32'd0);
    // Garbage data with valid still high while busy must be ignored.
    data_in3 = ~data_in3;
    data_in4 = ~data_in4;
    cyc = 0;
    while (!m_valid_out && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, "_latency"}, 32'(cyc), 32'(n_exp));
    chk({name, "_data"}, 32'(m_data), 32'(exp_d));
    chk({name, "_zero"}, 32'(m_zero), 32'(exp_z));
    chk({name, "_sat"}, 32'(m_sat), 32'(exp_s));
    chk({name, "_ready_in_done"}, 32'(m_ready_in), 32'd0);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      chk({name, "_stall_valid"}, 32'(m_valid_out), 32'd1);
      chk({name, "_stall_data"}, 32'(m_data), 32'(exp_d));
      chk({name, "_stall_flags"}, 32'({m_zero, m_sat}), 32'({exp_z, exp_s}));
      chk({name, "_stall_ready_in"}, 32'(m_ready_in), 32'd0);
    end
    valid_in3 = 1'b0;
    valid_in4 = 1'b0;
    if (sel4) ready_out4 = 1'b1; else ready_out3 = 1'b1;
    @(posedge clk); #1;
    ready_out3 = 1'b0;
    ready_out4 = 1'b0;
    chk({name, "_valid_out_cleared"}, 32'(m_valid_out), 32'd0);
    chk({name, "_ready_in_back"}, 32'(m_ready_in), 32'd1);
    $display("txn %s: data_out=0x%04h zero=%0d sat=%0d latency=%0d", name, m_data, m_zero, m_sat, cyc);
  endtask

  initial begin
    #3 rst_n = 1'b0;
    #1;
    chk("rst_ready_in", 32'(ready_in3), 32'd1);
    chk("rst_valid_out", 32'(valid_out3), 32'd0);
    chk("rst_data_out", 32'(data_out3), 32'd0);
    chk("rst_flags", 32'({zero_out3, sat_out3}), 32'd0);
    chk("rst4_ready_in", 32'(ready_in4), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    sel4 = 1'b0;
    run_vec("v_1_2_2",  {16'h0000, 16'h0020, 16'h0020, 16'h0010}, 16'h0090, 1'b0, 1'b0, 0);
    run_vec("v_m3_0_4", {16'h0000, 16'h0040, 16'h0000, 16'hFFD0}, 16'h0190, 1'b0, 1'b0, 5);
    run_vec("v_sat",    {16'h0000, 16'h0000, 16'h8000, 16'h7FFF}, 16'h7FFF, 1'b0, 1'b1, 0);
    run_vec("v_trunc0", {16'h0000, 16'h0000, 16'h0000, 16'h0001}, 16'h0000, 1'b1, 1'b0, 0);
    run_vec("v_again",  {16'h0000, 16'h0020, 16'h0020, 16'h0010}, 16'h0090, 1'b0, 1'b0, 0);

    // Reset during the second MAC cycle.
    data_in3 = {16'h0040, 16'h0000, 16'hFFD0};
    valid_in3 = 1'b1;
    @(posedge clk); #1;
    valid_in3 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_ready_in", 32'(ready_in3), 32'd1);
    chk("abort_valid_out", 32'(valid_out3), 32'd0);
    chk("abort_data_out", 32'(data_out3), 32'd0);
    chk("abort_flags", 32'({zero_out3, sat_out3}), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("abort_no_valid", 32'(valid_out3), 32'd0);
    end
    rst_n = 1'b1;
    $display("txn abort: reset mid-MAC, outputs cleared");
    @(posedge clk); #1;

    run_vec("post_rst", {16'h0000, 16'h0040, 16'h0000, 16'hFFD0}, 16'h0190, 1'b0, 1'b0, 0);
    sel4 = 1'b1;
    #1;
    run_vec("q4_ones",  {16'h0010, 16'h0010, 16'h0010, 16'h0010}, 16'h0040, 1'b0, 1'b0, 0);
    run_vec("q4_sat",   {16'h8000, 16'h0000, 16'h0000, 16'h0000}, 16'h7FFF, 1'b0, 1'b1, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
